spi_frame_fsm: RTL and testbench

Serial-frame decoder that sits directly downstream of the input conditioners on the SPI-style peripheral pins. It consumes conditioned chip-select, conditioned MOSI and the one-cycle SCLK edge pulses, and assembles address/command and data bits. It then issues one-cycle write or read requests to the register/memory block and shifts read data back out on MISO.

---
 rtl/spi_frame_fsm_if.sv | 27 ++
 rtl/spi_frame_fsm.sv | 166 ++++++++++++++++
 tb/tb_spi_frame_fsm.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_fsm_if.sv
// rtl/spi_frame_fsm_if.sv - register/memory request bus between the SPI frame decoder and its target
interface spi_frame_fsm_if #(
    parameter int addrwidth = 7,
    parameter int datawidth = 8
);
    logic [addrwidth-1:0] addr;
    logic [datawidth-1:0] wr_data;
    logic                 wr_en;
    logic                 rd_req;
    logic [datawidth-1:0] rd_data;

    modport master (
        output addr,
        output wr_data,
        output wr_en,
        output rd_req,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  wr_data,
        input  wr_en,
        input  rd_req,
        output rd_data
    );
endinterface

// File: rtl/spi_frame_fsm.sv
// rtl/spi_frame_fsm.sv - SPI-style serial frame decoder issuing register read/write requests
module spi_frame_fsm #(
    parameter int addrwidth = 7,
    parameter int datawidth = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_cond,
    input  logic sclk_posedge,
    input  logic sclk_negedge,
    input  logic mosi_cond,
    output logic miso,
    output logic miso_oe,
    output logic busy,
    spi_frame_fsm_if.master bus
);
    localparam int cmdbits    = addrwidth + 1;
    localparam int shiftwidth = (cmdbits > datawidth) ? cmdbits : datawidth;
    localparam int cntwidth   = $clog2(shiftwidth + 1);

    localparam logic [cntwidth-1:0] cmd_last  = cntwidth'(cmdbits - 1);
    localparam logic [cntwidth-1:0] data_last = cntwidth'(datawidth - 1);
    localparam logic [cntwidth-1:0] cnt_one   = cntwidth'(1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RD_REQ,
        RD_LOAD,
        RD_SHIFT,
        WR_DATA,
        WR_COMMIT,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [cntwidth-1:0]    cnt_q, cnt_d;
    logic [shiftwidth-1:0]  shift_q, shift_d;
    logic [addrwidth-1:0]   addr_q, addr_d;
    logic [datawidth-1:0]   wr_data_q, wr_data_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;

    logic                   pos_act;
    logic                   neg_act;
    logic [shiftwidth-1:0]  shift_in;

    // Edge pulses only count while selected; a rising edge wins over a coincident falling edge
    always_comb begin
        pos_act  = sclk_posedge & ~cs_cond;
        neg_act  = sclk_negedge & ~sclk_posedge & ~cs_cond;
        shift_in = {shift_q[shiftwidth-2:0], mosi_cond};
    end

    // Next-state and datapath decode; chip-select release aborts any frame in progress
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        miso_d    = miso_q;
        miso_oe_d = miso_oe_q;

        if (cs_cond && (state_q != IDLE)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            miso_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!cs_cond) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (pos_act) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + cnt_one;
                        if (cnt_q == cmd_last) begin
                            // Address bits are already in the register; the bit arriving now is R/W
                            addr_d  = shift_q[addrwidth-1:0];
                            cnt_d   = '0;
                            state_d = mosi_cond ? RD_REQ : WR_DATA;
                        end
                    end
                end
                RD_REQ: begin
                    state_d = RD_LOAD;
                end
                RD_LOAD: begin
                    shift_d = shiftwidth'(bus.rd_data);
                    cnt_d   = '0;
                    state_d = RD_SHIFT;
                end
                RD_SHIFT: begin
                    if (neg_act) begin
                        miso_d    = shift_q[datawidth-1];
                        miso_oe_d = 1'b1;
                        shift_d   = shift_q << 1;
                        cnt_d     = cnt_q + cnt_one;
                        if (cnt_q == data_last) begin
                            state_d = DONE;
                        end
                    end
                end
                WR_DATA: begin
                    if (pos_act) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + cnt_one;
                        if (cnt_q == data_last) begin
                            wr_data_d = shift_in[datawidth-1:0];
                            state_d   = WR_COMMIT;
                        end
                    end
                end
                WR_COMMIT: begin
                    state_d = DONE;
                end
                DONE: begin
                    // Frame complete: extra clocks are ignored until chip select releases
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            miso_q    <= miso_d;
            miso_oe_q <= miso_oe_d;
        end
    end

    // Strobes are decoded from the one-cycle commit/request states so each lasts exactly one clk
    always_comb begin
        bus.addr    = addr_q;
        bus.wr_data = wr_data_q;
        bus.wr_en   = (state_q == WR_COMMIT);
        bus.rd_req  = (state_q == RD_REQ);
        miso        = miso_q;
        miso_oe     = miso_oe_q;
        busy        = (state_q != IDLE);
    end

    // Read and write strobes come from distinct states and can never overlap
    assert property (@(posedge clk) disable iff (!rst_n) !(bus.wr_en && bus.rd_req));

endmodule

// File: tb/tb_spi_frame_fsm.sv
// tb/tb_spi_frame_fsm.sv - randomized self-checking bench for spi_frame_fsm
module tb_spi_frame_fsm;
    logic clk;
    logic rst_n;
    logic cs_cond;
    logic sclk_posedge;
    logic sclk_negedge;
    logic mosi_cond;
    logic miso;
    logic miso_oe;
    logic busy;

    spi_frame_fsm_if #(.addrwidth(7), .datawidth(8)) bus_if ();

    spi_frame_fsm #(.addrwidth(7), .datawidth(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cs_cond      (cs_cond),
        .sclk_posedge (sclk_posedge),
        .sclk_negedge (sclk_negedge),
        .mosi_cond    (mosi_cond),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .busy         (busy),
        .bus          (bus_if.master)
    );

    int checks = 0;
    int failures = 0;

    int wr_total = 0;
    int rd_total = 0;
    int overlap_total = 0;
    logic [6:0] last_wr_addr = '0;
    logic [7:0] last_wr_data = '0;
    logic [6:0] last_rd_addr = '0;
    logic       rd_req_seen = 1'b0;
    logic [7:0] rd_value = 8'h00;

    logic [6:0] exp_addr = '0;
    logic [7:0] exp_wdata = '0;

    logic samp_miso [0:31];
    logic samp_oe   [0:31];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus target model: counts strobes, returns read data only in the cycle after rd_req
    always @(negedge clk) begin
        if (bus_if.wr_en) begin
            wr_total++;
            last_wr_addr = bus_if.addr;
            last_wr_data = bus_if.wr_data;
        end
        if (bus_if.rd_req) begin
            rd_total++;
            last_rd_addr = bus_if.addr;
        end
        if (bus_if.wr_en && bus_if.rd_req) overlap_total++;
        bus_if.rd_data = rd_req_seen ? rd_value : ~rd_value;
        rd_req_seen = bus_if.rd_req;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sclk_bit(input logic b, output logic m, output logic oe);
        int h;
        h = $urandom_range(6, 4);
        mosi_cond = b;
        repeat (h) tick();
        sclk_posedge = 1'b1;
        tick();
        sclk_posedge = 1'b0;
        mosi_cond = 1'($urandom);
        repeat (h) tick();
        sclk_negedge = 1'b1;
        tick();
        sclk_negedge = 1'b0;
        m = miso;
        oe = miso_oe;
    endtask

    task automatic drive_frame(input logic [31:0] bits, input int n);
        logic m, oe;
        for (int i = 0; i < n; i++) begin
            sclk_bit(bits[31-i], m, oe);
            samp_miso[i] = m;
            samp_oe[i] = oe;
        end
    endtask

    task automatic start_frame();
        cs_cond = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cs_cond = 1'b1;
        sclk_posedge = 1'b0;
        sclk_negedge = 1'b0;
        mosi_cond = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus_if.addr, bus_if.wr_data, bus_if.wr_en, bus_if.rd_req, miso, miso_oe, busy} !== 22'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {bus_if.addr, bus_if.wr_data, bus_if.wr_en, bus_if.rd_req, miso, miso_oe, busy});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write();
        int w0, r0;
        w0 = wr_total; r0 = rd_total;
        start_frame();
        drive_frame({7'h2A, 1'b0, 8'hC5, 16'h0}, 16);
        tick();
        checks++;
        if (wr_total - w0 !== 1) begin failures++; $display("FAIL write_wr_count: got %0d expected 1", wr_total - w0); end
        checks++;
        if (last_wr_addr !== 7'h2A) begin failures++; $display("FAIL write_addr: got %0h expected 2a", last_wr_addr); end
        checks++;
        if (last_wr_data !== 8'hC5) begin failures++; $display("FAIL write_data: got %0h expected c5", last_wr_data); end
        checks++;
        if (rd_total - r0 !== 0) begin failures++; $display("FAIL write_rd_count: got %0d expected 0", rd_total - r0); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL write_busy_done: got %b expected 1", busy); end
        cs_cond = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_release: got %b expected 0", busy); end
        exp_addr = 7'h2A;
        exp_wdata = 8'hC5;
        tick();
    endtask

    task automatic test_read();
        int w0, r0;
        logic [7:0] exp_seq;
        exp_seq = 8'b1010_0011;
        rd_value = 8'hA3;
        w0 = wr_total; r0 = rd_total;
        start_frame();
        drive_frame({7'h15, 1'b1, 24'h0}, 15);
        checks++;
        if (rd_total - r0 !== 1) begin failures++; $display("FAIL read_rd_count: got %0d expected 1", rd_total - r0); end
        checks++;
        if (last_rd_addr !== 7'h15) begin failures++; $display("FAIL read_addr: got %0h expected 15", last_rd_addr); end
        checks++;
        if (wr_total - w0 !== 0) begin failures++; $display("FAIL read_wr_count: got %0d expected 0", wr_total - w0); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (samp_oe[i] !== 1'b0) begin failures++; $display("FAIL read_cmd_oe[%0d]: got %b expected 0", i, samp_oe[i]); end
        end
        for (int i = 7; i < 15; i++) begin
            checks++;
            if (samp_miso[i] !== exp_seq[14-i] || samp_oe[i] !== 1'b1) begin
                failures++;
                $display("FAIL read_miso[%0d]: got miso=%b oe=%b expected miso=%b oe=1", i, samp_miso[i], samp_oe[i], exp_seq[14-i]);
            end
        end
        cs_cond = 1'b1;
        tick();
        checks++;
        if (miso_oe !== 1'b0) begin failures++; $display("FAIL read_oe_release: got %b expected 0", miso_oe); end
        exp_addr = 7'h15;
        tick();
    endtask

    task automatic test_abort();
        int w0;
        w0 = wr_total;
        start_frame();
        drive_frame({7'h33, 1'b0, 8'h5A, 16'h0}, 13);
        cs_cond = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle: got busy=%b expected 0", busy); end
        checks++;
        if (wr_total - w0 !== 0) begin failures++; $display("FAIL abort_no_wr: got %0d expected 0", wr_total - w0); end
        exp_addr = 7'h33;
        checks++;
        if (bus_if.wr_data !== exp_wdata) begin failures++; $display("FAIL abort_wdata_hold: got %0h expected %0h", bus_if.wr_data, exp_wdata); end
        start_frame();
        drive_frame({7'h01, 1'b0, 8'hFF, 16'h0}, 16);
        tick();
        checks++;
        if (wr_total - w0 !== 1 || last_wr_addr !== 7'h01 || last_wr_data !== 8'hFF) begin
            failures++;
            $display("FAIL abort_followup: got n=%0d addr=%0h data=%0h expected n=1 addr=1 data=ff",
                     wr_total - w0, last_wr_addr, last_wr_data);
        end
        exp_addr = 7'h01;
        exp_wdata = 8'hFF;
        cs_cond = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset_midframe();
        int w0;
        rd_value = 8'hA3;
        start_frame();
        drive_frame({7'h4C, 1'b1, 24'h0}, 10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({bus_if.addr, bus_if.wr_data, bus_if.wr_en, bus_if.rd_req, miso, miso_oe, busy} !== 22'h0) begin
            failures++;
            $display("FAIL midreset_outputs: got %0h expected 0",
                     {bus_if.addr, bus_if.wr_data, bus_if.wr_en, bus_if.rd_req, miso, miso_oe, busy});
        end
        exp_addr = '0;
        exp_wdata = '0;
        cs_cond = 1'b1;
        repeat (2) tick();
        w0 = wr_total;
        start_frame();
        drive_frame({7'h6E, 1'b0, 8'h3C, 16'h0}, 16);
        tick();
        checks++;
        if (wr_total - w0 !== 1 || last_wr_addr !== 7'h6E || last_wr_data !== 8'h3C) begin
            failures++;
            $display("FAIL midreset_followup: got n=%0d addr=%0h data=%0h expected n=1 addr=6e data=3c",
                     wr_total - w0, last_wr_addr, last_wr_data);
        end
        exp_addr = 7'h6E;
        exp_wdata = 8'h3C;
        cs_cond = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_ignored_edges();
        int w0, r0;
        logic [6:0] a;
        w0 = wr_total; r0 = rd_total;
        cs_cond = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mosi_cond = 1'($urandom);
            sclk_posedge = 1'b1; tick(); sclk_posedge = 1'b0; tick();
            sclk_negedge = 1'b1; tick(); sclk_negedge = 1'b0; tick();
            checks++;
            if (busy !== 1'b0) begin failures++; $display("FAIL ignored_busy[%0d]: got %b expected 0", i, busy); end
        end
        checks++;
        if (wr_total != w0 || rd_total != r0) begin
            failures++;
            $display("FAIL ignored_strobes: got wr=%0d rd=%0d expected 0 0", wr_total - w0, rd_total - r0);
        end
        a = exp_addr ^ 7'h55;
        start_frame();
        drive_frame({a, 1'b0, 24'h0}, 7);
        mosi_cond = 1'b0;
        cs_cond = 1'b1;
        sclk_posedge = 1'b1;
        tick();
        sclk_posedge = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus_if.addr !== exp_addr) begin
            failures++;
            $display("FAIL coincident_cs_edge: got busy=%b addr=%0h expected busy=0 addr=%0h", busy, bus_if.addr, exp_addr);
        end
        tick();
    endtask

    task automatic test_overrun();
        int w0;
        w0 = wr_total;
        start_frame();
        drive_frame({7'h47, 1'b0, 8'h9B, 8'hFF, 8'h00}, 20);
        checks++;
        if (wr_total - w0 !== 1) begin failures++; $display("FAIL overrun_wr_count: got %0d expected 1", wr_total - w0); end
        checks++;
        if (bus_if.addr !== 7'h47 || bus_if.wr_data !== 8'h9B) begin
            failures++;
            $display("FAIL overrun_hold: got addr=%0h data=%0h expected 47 9b", bus_if.addr, bus_if.wr_data);
        end
        exp_addr = 7'h47;
        exp_wdata = 8'h9B;
        cs_cond = 1'b1;
        repeat (2) tick();
    endtask

    // Reference: a frame of n clocked bits after a fresh select either reaches a complete
    // command (n>=8) and/or complete write data (n>=16); read data appears on the falling
    // edges from bit index 7 onward, MSB first, holding the last bit afterwards.
    task automatic test_random();
        for (int f = 0; f < 24; f++) begin
            int n, w0, r0, k;
            logic rw, exp_oe, exp_m;
            logic [6:0] a;
            logic [7:0] d;
            int exp_wr, exp_rd;
            rw = 1'($urandom);
            a = 7'($urandom);
            d = 8'($urandom);
            n = $urandom_range(24, 2);
            rd_value = 8'($urandom);
            w0 = wr_total; r0 = rd_total;
            exp_wr = (!rw && n >= 16) ? 1 : 0;
            exp_rd = (rw && n >= 8) ? 1 : 0;
            start_frame();
            drive_frame({a, rw, d, 16'($urandom)}, n);
            tick();
            checks++;
            if (wr_total - w0 !== exp_wr || rd_total - r0 !== exp_rd) begin
                failures++;
                $display("FAIL rand%0d_strobes: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
                         f, wr_total - w0, rd_total - r0, exp_wr, exp_rd);
            end
            if (n >= 8) exp_addr = a;
            if (exp_wr == 1) exp_wdata = d;
            if (exp_wr == 1) begin
                checks++;
                if (last_wr_addr !== a || last_wr_data !== d) begin
                    failures++;
                    $display("FAIL rand%0d_wr: got addr=%0h data=%0h expected %0h %0h", f, last_wr_addr, last_wr_data, a, d);
                end
            end
            if (exp_rd == 1) begin
                checks++;
                if (last_rd_addr !== a) begin failures++; $display("FAIL rand%0d_rd_addr: got %0h expected %0h", f, last_rd_addr, a); end
            end
            for (int i = 0; i < n; i++) begin
                exp_oe = rw && (i >= 7);
                k = (i - 7 > 7) ? 7 : i - 7;
                exp_m = exp_oe ? rd_value[7-k] : 1'b0;
                checks++;
                if (samp_oe[i] !== exp_oe || (exp_oe && samp_miso[i] !== exp_m)) begin
                    failures++;
                    $display("FAIL rand%0d_miso[%0d]: got miso=%b oe=%b expected miso=%b oe=%b",
                             f, i, samp_miso[i], samp_oe[i], exp_m, exp_oe);
                end
            end
            cs_cond = 1'b1;
            tick();
            checks++;
            if (busy !== 1'b0 || miso_oe !== 1'b0 || bus_if.addr !== exp_addr || bus_if.wr_data !== exp_wdata) begin
                failures++;
                $display("FAIL rand%0d_end: got busy=%b oe=%b addr=%0h data=%0h expected 0 0 %0h %0h",
                         f, busy, miso_oe, bus_if.addr, bus_if.wr_data, exp_addr, exp_wdata);
            end
            tick();
        end
        checks++;
        if (overlap_total !== 0) begin failures++; $display("FAIL strobe_overlap: got %0d expected 0", overlap_total); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_reset_midframe();
        test_ignored_edges();
        test_overrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
